novacore_pio_status_in: RTL and testbench

Avalon-MM slave input port: the host-facing reader for status bits from the NovaCORE array, the reverse of the output-PIO blocks that drive configuration such as the C dimension. External status lines are synchronised into the clock domain and rising edges are latched in a sticky capture register. A masked interrupt is raised toward the Nios host, which reads levels and captured edges and clears captures with write-1-to-clear.

---
 rtl/novacore_pio_pkg.sv | 12 +
 rtl/novacore_sync2.sv | 28 ++
 rtl/novacore_pio_status_in.sv | 118 +++++++++++
 tb/tb_novacore_pio_status_in.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/novacore_pio_pkg.sv
// Shared definitions for the NovaCORE PIO blocks: Avalon-MM register map
// and bus width.
package novacore_pio_pkg;

    localparam int unsigned BUS_W = 32;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

endpackage

// File: rtl/novacore_sync2.sv
// Parameterised two-flop synchroniser for asynchronous input lines.
// Each bit is synchronised on its own; there is no cross-bit coherency.
module novacore_sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;

    // Two-stage metastability filter, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= {WIDTH{1'b0}};
            sync2_r <= {WIDTH{1'b0}};
        end else begin
            sync1_r <= d;
            sync2_r <= sync1_r;
        end
    end

    assign q = sync2_r;

endmodule

// File: rtl/novacore_pio_status_in.sv
// Avalon-MM status input PIO for the NovaCORE array. Synchronises the
// status lines, latches rising edges in a sticky write-1-to-clear capture
// register and raises a masked, registered level interrupt to the host.
module novacore_pio_status_in
    import novacore_pio_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [WIDTH-1:0]  in_port,
    output logic              irq
);

    logic [WIDTH-1:0] sync2_s;
    logic [WIDTH-1:0] d_prev_r;
    logic [WIDTH-1:0] rise_s;
    logic             wr_en_s;
    logic             mask_wr_s;
    logic [WIDTH-1:0] clr_s;
    logic [WIDTH-1:0] irqmask_r;
    logic [WIDTH-1:0] edgecap_r;
    logic             irq_r;
    logic [31:0]      readdata_s;
    logic             unused_wdata_s;

    novacore_sync2 #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (sync2_s)
    );

    // Bits above WIDTH are accepted but have no effect.
    assign unused_wdata_s = ^writedata;

    assign wr_en_s = chipselect && !write_n;
    assign rise_s  = sync2_s & ~d_prev_r;

    // Decode host writes into a mask load strobe and a capture clear vector.
    always_comb begin
        mask_wr_s = 1'b0;
        clr_s     = {WIDTH{1'b0}};
        if (wr_en_s) begin
            case (address)
                ADDR_IRQMASK: mask_wr_s = 1'b1;
                ADDR_EDGECAP: clr_s     = writedata[WIDTH-1:0];
                default: begin
                    mask_wr_s = 1'b0;
                    clr_s     = {WIDTH{1'b0}};
                end
            endcase
        end else begin
            mask_wr_s = 1'b0;
            clr_s     = {WIDTH{1'b0}};
        end
    end

    // Delayed copy of the synchronised lines for rising-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_prev_r <= {WIDTH{1'b0}};
        end else begin
            d_prev_r <= sync2_s;
        end
    end

    // Interrupt mask register, loaded by host writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_r <= {WIDTH{1'b0}};
        end else if (mask_wr_s) begin
            irqmask_r <= writedata[WIDTH-1:0];
        end else begin
            irqmask_r <= irqmask_r;
        end
    end

    // Sticky edge capture; a new edge wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecap_r <= {WIDTH{1'b0}};
        end else begin
            edgecap_r <= (edgecap_r & ~clr_s) | rise_s;
        end
    end

    // Registered interrupt so the host sees a glitch-free level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |(edgecap_r & irqmask_r);
        end
    end

    // Zero-wait-state read mux; upper bits stay zero.
    always_comb begin
        readdata_s = 32'h0000_0000;
        case (address)
            ADDR_DATA:    readdata_s[WIDTH-1:0] = sync2_s;
            ADDR_IRQMASK: readdata_s[WIDTH-1:0] = irqmask_r;
            ADDR_EDGECAP: readdata_s[WIDTH-1:0] = edgecap_r;
            default:      readdata_s = 32'h0000_0000;
        endcase
    end

    assign readdata = readdata_s;
    assign irq      = irq_r;

endmodule

// File: tb/tb_novacore_pio_status_in.sv
// Self-checking bench for novacore_pio_status_in: directed scenarios followed
// by randomized traffic, all checked against a sample-history reference model.
`timescale 1ns/1ps
module tb_novacore_pio_status_in;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  in_port;
    logic        irq;

    int total_cnt = 0;
    int bad_cnt   = 0;

    // Reference model: hist[k] is the in_port value sampled k+1 edges ago.
    logic [3:0] m_hist [3];
    logic [3:0] m_ec;
    logic [3:0] m_mask;
    logic       m_irq;
    logic [3:0] in_cur;

    novacore_pio_status_in #(.WIDTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_hist[i] = 4'h0;
        m_ec   = 4'h0;
        m_mask = 4'h0;
        m_irq  = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'h0, m_hist[1]};
            2'd2:    return {28'h0, m_mask};
            2'd3:    return {28'h0, m_ec};
            default: return 32'h0;
        endcase
    endfunction

    // One clock edge of the model: DATA is the input two samples late, a
    // capture sets when DATA goes 0->1, irq follows capture&mask one edge late.
    task automatic model_edge(input logic cs, input logic wr, input logic [1:0] a,
                              input logic [31:0] d, input logic [3:0] in_v);
        logic [3:0] rise;
        logic [3:0] clr;
        logic       wen;
        rise  = m_hist[1] & ~m_hist[2];
        wen   = cs && wr;
        clr   = (wen && a == 2'd3) ? d[3:0] : 4'h0;
        m_irq = |(m_ec & m_mask);
        m_ec  = (m_ec & ~clr) | rise;
        if (wen && a == 2'd2) m_mask = d[3:0];
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = in_v;
    endtask

    // Check outputs mid-cycle, drive the next cycle's inputs, advance the model.
    task automatic step(input logic cs, input logic wr, input logic [1:0] a,
                        input logic [31:0] d, input logic [3:0] in_v);
        @(negedge clk);
        check_eq("irq", {31'h0, irq}, {31'h0, m_irq});
        check_eq($sformatf("rd_a%0d", address), readdata, model_read(address));
        chipselect = cs;
        write_n    = !wr;
        address    = a;
        writedata  = d;
        in_port    = in_v;
        in_cur     = in_v;
        @(posedge clk);
        model_edge(cs, wr, a, d, in_v);
    endtask

    task automatic idle(input logic [1:0] a, input logic [3:0] in_v);
        step(1'b1, 1'b0, a, 32'h0, in_v);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d, input logic [3:0] in_v);
        step(1'b1, 1'b1, a, d, in_v);
    endtask

    // Read a register shortly after an edge without disturbing state.
    task automatic peek(input string tag, input logic [1:0] a, input logic [31:0] exp);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = a;
        #1;
        check_eq(tag, readdata, exp);
    endtask

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'h0;
        in_port    = 4'hF;
        in_cur     = 4'hF;
        model_reset();

        // Reset state with all inputs high.
        #3;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            check_eq("rst_read", readdata, 32'h0);
        end
        check_eq("rst_irq", {31'h0, irq}, 32'h0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 6; i++) idle(2'(i), 4'hF);
        peek("post_rst_data", 2'd0, 32'hF);
        peek("post_rst_ecap", 2'd3, 32'hF);

        // Level read of 0xA after clearing old captures.
        wr_reg(2'd3, 32'hF, 4'h0);
        for (int i = 0; i < 4; i++) idle(2'd3, 4'h0);
        wr_reg(2'd3, 32'hF, 4'h0);
        for (int i = 0; i < 5; i++) idle(2'(i), 4'hA);
        peek("level_data", 2'd0, 32'hA);
        peek("level_ecap", 2'd3, 32'hA);
        check_eq("level_irq", {31'h0, irq}, 32'h0);

        // Interrupt on bit 1 and its clear.
        for (int i = 0; i < 3; i++) idle(2'd0, 4'h0);
        wr_reg(2'd3, 32'hF, 4'h0);
        wr_reg(2'd2, 32'h2, 4'h0);
        idle(2'd2, 4'h0);
        idle(2'd3, 4'h2);
        idle(2'd3, 4'h2);
        idle(2'd3, 4'h2);
        peek("irq_ecap", 2'd3, 32'h2);
        check_eq("irq_not_yet", {31'h0, irq}, 32'h0);
        idle(2'd3, 4'h0);
        #1 check_eq("irq_lat3", {31'h0, irq}, 32'h1);
        idle(2'd3, 4'h0);
        wr_reg(2'd3, 32'h2, 4'h0);
        peek("clr_ecap", 2'd3, 32'h0);
        check_eq("irq_hold", {31'h0, irq}, 32'h1);
        idle(2'd3, 4'h0);
        #1 check_eq("irq_fall", {31'h0, irq}, 32'h0);

        // Set beats clear on the same edge.
        idle(2'd3, 4'h1);
        idle(2'd3, 4'h1);
        wr_reg(2'd3, 32'h1, 4'h1);
        peek("set_wins", 2'd3, 32'h1);
        idle(2'd3, 4'h0);
        idle(2'd3, 4'h0);

        // Masking keeps the capture; unmask re-raises irq.
        wr_reg(2'd3, 32'hF, 4'h0);
        wr_reg(2'd2, 32'h4, 4'h0);
        for (int i = 0; i < 5; i++) idle(2'd3, 4'h4);
        #1 check_eq("mask_irq_on", {31'h0, irq}, 32'h1);
        wr_reg(2'd2, 32'h0, 4'h4);
        idle(2'd3, 4'h4);
        #1 check_eq("mask_irq_off", {31'h0, irq}, 32'h0);
        peek("mask_ecap", 2'd3, 32'h4);
        wr_reg(2'd2, 32'h4, 4'h4);
        idle(2'd3, 4'h4);
        #1 check_eq("unmask_irq", {31'h0, irq}, 32'h1);

        // Reserved address and unselected write.
        wr_reg(2'd1, 32'hFFFF_FFFF, 4'h4);
        peek("rsvd_read", 2'd1, 32'h0);
        peek("rsvd_mask", 2'd2, 32'h4);
        peek("rsvd_ecap", 2'd3, 32'h4);
        step(1'b0, 1'b1, 2'd2, 32'h0, 4'h4);
        peek("nocs_mask", 2'd2, 32'h4);

        // Asynchronous reset in the middle of a pulse while irq is high.
        idle(2'd3, 4'hF);
        idle(2'd3, 4'hF);
        @(negedge clk);
        check_eq("pre_rst_irq", {31'h0, irq}, 32'h1);
        #2 reset_n = 1'b0;
        #1 check_eq("async_irq", {31'h0, irq}, 32'h0);
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            check_eq("async_read", readdata, 32'h0);
        end
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] nxt;
            nxt = in_cur ^ (4'($urandom) & 4'($urandom));
            step(($urandom_range(0, 4) != 0), ($urandom_range(0, 3) == 0),
                 2'($urandom_range(0, 3)), $urandom, nxt);
        end
        idle(2'd0, in_cur);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
